// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined CLA adder.
package adder_pkg;

  typedef struct packed {
    logic carry;
    logic sub;
    logic msb_cin;
  } stage_ctl_t;

  function automatic int ngroup(int w, int gw);
    return w / gw;
  endfunction

  function automatic int nstage(int w, int gw, int gps);
    return (w / gw) / gps;
  endfunction

  function automatic bit cfg_ok(int w, int gw, int gps);
    return (gw > 0) && (gps > 0) && (w % gw == 0) &&
           ((w / gw) % gps == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// One combinational carry look-ahead group with group P/G and
// the carry into its top bit for signed overflow detection.
module cla_group
  import adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         p_o,
  output logic         g_o,
  output logic         ctop_o
);

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;
  logic         gg;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  always_comb begin
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  always_comb begin
    gg = 1'b0;
    for (int i = 0; i < W; i++) begin
      gg = g[i] | (p[i] & gg);
    end
  end

  assign sum_o  = p ^ c[W-1:0];
  assign cout_o = c[W];
  assign ctop_o = c[W-1];
  assign p_o    = &p;
  assign g_o    = gg;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/sub built from CLA groups; the group carry ripples
// through a register every GPS groups, with valid/ready backpressure.
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int GROUP_W = 4,
  parameter int GPS     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NG = ngroup(WIDTH, GROUP_W);
  localparam int L  = nstage(WIDTH, GROUP_W, GPS);

  if (!cfg_ok(WIDTH, GROUP_W, GPS)) begin : g_cfg_err
    $error("pipelined_cla_adder: bad WIDTH/GROUP_W/GPS");
  end

  logic               en_q;
  logic [L-1:0]       v_q;
  logic [L:0]         rdy;
  logic [L-1:0]       vin;
  logic [WIDTH-1:0]   sum_q [L];
  logic [WIDTH-1:0]   sum_d [L];
  logic [WIDTH-1:0]   a_q   [L];
  logic [WIDTH-1:0]   a_d   [L];
  logic [WIDTH-1:0]   b_q   [L];
  logic [WIDTH-1:0]   b_d   [L];
  stage_ctl_t         ctl_q [L];
  stage_ctl_t         ctl_d [L];

  logic [WIDTH-1:0]   b_eff;
  logic               cin_eff;
  logic [GROUP_W-1:0] gs  [NG];
  logic               gco [NG];
  logic               gct [NG];
  logic               gp  [NG];
  logic               gg  [NG];
  logic [NG-1:0]      gci;

  assign b_eff   = in_b ^ {WIDTH{in_sub}};
  assign cin_eff = in_cin ^ in_sub;

  for (genvar i = 0; i < NG; i++) begin : g_grp
    localparam int K = i / GPS;
    logic [GROUP_W-1:0] ga;
    logic [GROUP_W-1:0] gb;
    if (K == 0) begin : g_s0
      assign ga = in_a[i*GROUP_W +: GROUP_W];
      assign gb = b_eff[i*GROUP_W +: GROUP_W];
    end else begin : g_sk
      assign ga = a_q[K-1][i*GROUP_W +: GROUP_W];
      assign gb = b_q[K-1][i*GROUP_W +: GROUP_W];
    end
    cla_group #(.W(GROUP_W)) u_cla (
      .a_i    (ga),
      .b_i    (gb),
      .cin_i  (gci[i]),
      .sum_o  (gs[i]),
      .cout_o (gco[i]),
      .p_o    (gp[i]),
      .g_o    (gg[i]),
      .ctop_o (gct[i])
    );
  end

  // First group of a stage takes the previous stage's registered carry
  always_comb begin
    gci = '0;
    for (int i = 0; i < NG; i++) begin
      if (i == 0)
        gci[i] = cin_eff;
      else if (i % GPS == 0)
        gci[i] = ctl_q[i/GPS-1].carry;
      else
        gci[i] = gg[i-1] | (gp[i-1] & gci[i-1]);
    end
  end

  always_comb begin
    rdy    = '0;
    rdy[L] = out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      rdy[k] = ~v_q[k] | rdy[k+1];
    end
  end

  always_comb begin
    for (int k = 0; k < L; k++) begin
      if (k == 0) begin
        vin[k]       = in_valid & en_q;
        a_d[k]       = in_a;
        b_d[k]       = b_eff;
        sum_d[k]     = '0;
        ctl_d[k].sub = in_sub;
      end else begin
        vin[k]       = v_q[k-1];
        a_d[k]       = a_q[k-1];
        b_d[k]       = b_q[k-1];
        sum_d[k]     = sum_q[k-1];
        ctl_d[k].sub = ctl_q[k-1].sub;
      end
      for (int j = 0; j < GPS; j++) begin
        sum_d[k][(k*GPS+j)*GROUP_W +: GROUP_W] = gs[k*GPS+j];
      end
      ctl_d[k].carry   = gco[k*GPS+GPS-1];
      ctl_d[k].msb_cin = (k == L - 1) ? gct[NG-1] : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= 1'b0;
      v_q  <= '0;
      for (int k = 0; k < L; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        ctl_q[k] <= '0;
      end
    end else begin
      en_q <= 1'b1;
      for (int k = 0; k < L; k++) begin
        if (rdy[k])
          v_q[k] <= vin[k];
        if (rdy[k] & vin[k]) begin
          sum_q[k] <= sum_d[k];
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          ctl_q[k] <= ctl_d[k];
        end
      end
    end
  end

  assign in_ready  = rdy[0] & en_q;
  assign out_valid = v_q[L-1];
  assign out_sum   = sum_q[L-1];
  assign out_cout  = ctl_q[L-1].carry;
  assign out_ovf   = ctl_q[L-1].carry ^ ctl_q[L-1].msb_cin;
  assign out_zero  = v_q[L-1] & ~|sum_q[L-1];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed table, backpressure, soak and mid-flight reset checks
// for pipelined_cla_adder at WIDTH=32, GROUP_W=4, GPS=2.
module tb_pipelined_cla_adder;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(32), .GROUP_W(4), .GPS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          rcv = 0;
  int          bi;
  int          cyc;
  int          sent_n;
  logic        sent;
  logic [34:0] exp0;
  logic [34:0] exp_q[$];
  vec_t        tbl[12];
  vec_t        rv;
  logic [31:0] ba[10];
  logic [31:0] bb[10];
  logic        bs[10];
  logic        bc[10];

  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [31:0] bx;
    logic [32:0] r;
    logic        c;
    logic        ovf;
    bx  = sub ? ~b : b;
    c   = sub ? ~cin : cin;
    r   = {1'b0, a} + {1'b0, bx} + {32'b0, c};
    ovf = (a[31] == bx[31]) && (r[31] != a[31]);
    return {r[31:0], r[32], ovf, r[31:0] == 32'h0};
  endfunction

  function automatic logic [34:0] outs();
    return {out_sum, out_cout, out_ovf, out_zero};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub, input logic ordy,
                      output logic snt);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_sub    = sub;
    out_ready = ordy;
    #1;
    snt = v & in_ready;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_beat: got sum 0x%0h want no beat", out_sum);
      end else begin
        chk($sformatf("beat%0d", rcv), outs(), exp_q.pop_front());
      end
      rcv++;
    end
    if (snt) exp_q.push_back(model(a, b, cin, sub));
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t t, input string nm);
    in_valid  = 1'b1;
    in_a      = t.a;
    in_b      = t.b;
    in_cin    = t.cin;
    in_sub    = t.sub;
    out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_cin   = ~t.cin;
    in_sub   = ~t.sub;
    for (int e = 1; e < L; e++) begin
      chk($sformatf("%s_early%0d", nm, e), out_valid, 0);
      @(negedge clk);
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_result"}, outs(), {t.sum, t.cout, t.ovf, t.zero});
    @(negedge clk);
    chk({nm, "_drained"}, out_valid, 0);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready_pre_edge", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_post_edge", in_ready, 1);

    tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{32'h00001234, 32'h00001234, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: fill the pipe, hold, then release and drain in order
    for (int i = 0; i < 10; i++) begin
      ba[i] = 32'h11111111 * (i + 1);
      bb[i] = 32'h00000003 * i + 32'h1;
      bs[i] = (i % 2) == 1;
      bc[i] = (i % 4) >= 2;
    end
    exp0 = model(ba[0], bb[0], bc[0], bs[0]);
    exp_q.delete();
    rcv = 0;
    bi  = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, ba[bi], bb[bi], bc[bi], bs[bi], 1'b0, sent);
      chk($sformatf("bp_accept%0d", c), sent, 1);
      if (sent) bi++;
    end
    for (int h = 0; h < 3; h++) begin
      in_valid  = 1'b1;
      in_a      = ba[bi];
      in_b      = bb[bi];
      in_cin    = bc[bi];
      in_sub    = bs[bi];
      out_ready = 1'b0;
      #1;
      chk($sformatf("bp_full_in_ready%0d", h), in_ready, 0);
      chk($sformatf("bp_hold_valid%0d", h), out_valid, 1);
      chk($sformatf("bp_hold_out%0d", h), outs(), exp0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    cyc = 0;
    while ((bi < 10 || exp_q.size() != 0) && cyc < 200) begin
      if (bi < 10) step(1'b1, ba[bi], bb[bi], bc[bi], bs[bi], 1'b1, sent);
      else         step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, sent);
      if (sent) bi++;
      cyc++;
    end
    if (cyc >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL bp_timeout: got %0d beats want 10", rcv);
    end
    chk("bp_count", rcv, 10);

    // Random soak against the reference model
    exp_q.delete();
    rcv    = 0;
    sent_n = 0;
    cyc    = 0;
    while (sent_n < 10000 && cyc < 60000) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
           ($urandom_range(0, 7) == 0) ? 32'h00000000 : $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), sent);
      if (sent) sent_n++;
      cyc++;
    end
    while (exp_q.size() != 0 && cyc < 61000) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, sent);
      cyc++;
    end
    chk("soak_sent", sent_n, 10000);
    chk("soak_rcv", rcv, sent_n);
    chk("soak_left", exp_q.size(), 0);

    // Mid-flight asynchronous reset
    exp_q.delete();
    rcv = 0;
    for (int c = 0; c < 3; c++)
      step(1'b1, 32'h100 + c, 32'h1, 1'b0, 1'b0, 1'b0, sent);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, sent);
    chk("mid_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_outputs", outs(), 0);
    @(negedge clk);
    chk("mid_rst_hold", out_valid, 0);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rel_in_ready", in_ready, 0);
    @(negedge clk);
    chk("mid_no_stale", out_valid, 0);
    rv = '{32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b0};
    run_vec(rv, "mid_recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
